// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: turns RV32I instruction fields into machine words,
// queues them in a small FIFO and writes them into instruction memory at
// consecutive word addresses.
module instr_stream_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_kind,
  input  logic [4:0]             cmd_rd,
  input  logic [4:0]             cmd_rs1,
  input  logic [4:0]             cmd_rs2,
  input  logic [2:0]             cmd_funct3,
  input  logic [6:0]             cmd_funct7,
  input  logic [11:0]            cmd_imm,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   err_illegal,
  output logic                   addr_wrap
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] KIND_R      = 3'd0;
  localparam logic [2:0] KIND_LOAD   = 3'd1;
  localparam logic [2:0] KIND_STORE  = 3'd2;
  localparam logic [2:0] KIND_BRANCH = 3'd3;
  localparam logic [2:0] KIND_OPIMM  = 3'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        push;
  logic        pop;

  // Field placement for each supported instruction class.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (cmd_kind)
      KIND_R:
        enc_word = {cmd_funct7, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, OP_R};
      KIND_LOAD:
        enc_word = {cmd_imm, cmd_rs1, cmd_funct3, cmd_rd, OP_LOAD};
      KIND_STORE:
        enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], OP_STORE};
      KIND_BRANCH:
        // cmd_imm carries byte-offset bits [12:1], so index k here is offset bit k+1.
        enc_word = {cmd_imm[11], cmd_imm[9:4], cmd_rs2, cmd_rs1, cmd_funct3,
                    cmd_imm[3:0], cmd_imm[10], OP_BRANCH};
      KIND_OPIMM: begin
        // Shifts carry funct7 in the top bits and only a 5-bit shift amount.
        if (cmd_funct3 == 3'b001 || cmd_funct3 == 3'b101) begin
          enc_word = {cmd_funct7, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, OP_OPIMM};
        end else begin
          enc_word = {cmd_imm, cmd_rs1, cmd_funct3, cmd_rd, OP_OPIMM};
        end
      end
      default:
        enc_legal = 1'b0;
    endcase
  end

  // Handshake decode; readiness looks only at registered occupancy.
  always_comb begin
    cmd_ready = (count_q < CNT_W'(DEPTH));
    mem_we    = (count_q != '0);
    accept    = cmd_valid && cmd_ready;
    push      = accept && enc_legal;
    pop       = mem_we && mem_ready;
  end

  // Next-state for pointers, occupancy, address counter and sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = err_q;
    wrap_d   = wrap_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      addr_d   = addr_q + 1'b1;
      if (addr_q == '1) begin
        wrap_d = 1'b1;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (accept && !enc_legal) begin
      err_d = 1'b1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
    end
  end

  // Word storage; contents are don't-care until the occupancy says valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_q[wr_ptr_q] <= enc_word;
    end
  end

  // Memory-side outputs; data reads as zero while nothing is queued.
  always_comb begin
    mem_addr    = addr_q;
    mem_wdata   = mem_we ? fifo_q[rd_ptr_q] : 32'd0;
    pending     = count_q;
    err_illegal = err_q;
    addr_wrap   = wrap_q;
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Testbench for instr_stream_encoder: fixed vectors, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_instr_stream_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd_kind;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [2:0]  cmd_funct3;
  logic [6:0]  cmd_funct7;
  logic [11:0] cmd_imm;
  logic        mem_ready;

  logic        cmd_ready_a, mem_we_a, err_illegal_a, addr_wrap_a;
  logic [7:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [2:0]  pending_a;

  logic        cmd_ready_b, mem_we_b, err_illegal_b, addr_wrap_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [2:0]  pending_b;

  instr_stream_encoder #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
    .cmd_kind(cmd_kind), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_funct3(cmd_funct3), .cmd_funct7(cmd_funct7), .cmd_imm(cmd_imm),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_ready(mem_ready), .pending(pending_a), .err_illegal(err_illegal_a),
    .addr_wrap(addr_wrap_a)
  );

  instr_stream_encoder #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_kind(cmd_kind), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_funct3(cmd_funct3), .cmd_funct7(cmd_funct7), .cmd_imm(cmd_imm),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_ready(mem_ready), .pending(pending_b), .err_illegal(err_illegal_b),
    .addr_wrap(addr_wrap_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words waiting for memory, plus address/flag state.
  logic [31:0] mq[$];
  int unsigned m_addr_a, m_addr_b;
  bit          m_err, m_wrap_a, m_wrap_b;
  int          m_pushes;

  // Writes actually observed at the DUT memory ports.
  logic [31:0] log_addr_a[$], log_data_a[$], log_addr_b[$];

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [31:0] ref_encode(int unsigned kind, int unsigned rd,
      int unsigned rs1, int unsigned rs2, int unsigned f3, int unsigned f7,
      int unsigned imm);
    int unsigned w;
    int unsigned common;
    common = (f3 << 12) | (rs1 << 15);
    case (kind)
      0: w = 'h33 | (rd << 7) | common | (rs2 << 20) | (f7 << 25);
      1: w = 'h03 | (rd << 7) | common | (imm << 20);
      2: w = 'h23 | ((imm % 32) << 7) | common | (rs2 << 20) | ((imm / 32) << 25);
      3: w = 'h63 | (((imm >> 10) & 1) << 7) | ((imm & 'hF) << 8) | common
             | (rs2 << 20) | (((imm >> 4) & 'h3F) << 25) | (((imm >> 11) & 1) << 31);
      4: begin
        if (f3 == 1 || f3 == 5)
          w = 'h13 | (rd << 7) | common | ((imm % 32) << 20) | (f7 << 25);
        else
          w = 'h13 | (rd << 7) | common | (imm << 20);
      end
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cmd_ready", cmd_ready_a, mq.size() < DEPTH);
    chk("mem_we", mem_we_a, mq.size() != 0);
    chk("pending", pending_a, mq.size());
    chk("mem_addr", mem_addr_a, m_addr_a);
    if (mq.size() != 0) chk("mem_wdata", mem_wdata_a, mq[0]);
    chk("err_illegal", err_illegal_a, m_err);
    chk("addr_wrap", addr_wrap_a, m_wrap_a);
    chk("b_cmd_ready", cmd_ready_b, mq.size() < DEPTH);
    chk("b_mem_we", mem_we_b, mq.size() != 0);
    chk("b_pending", pending_b, mq.size());
    chk("b_mem_addr", mem_addr_b, m_addr_b);
    if (mq.size() != 0) chk("b_mem_wdata", mem_wdata_b, mq[0]);
    chk("b_err_illegal", err_illegal_b, m_err);
    chk("b_addr_wrap", addr_wrap_b, m_wrap_b);
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic step();
    bit do_pop, do_acc;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_addr_a = 0; m_addr_b = 0;
      m_err = 0; m_wrap_a = 0; m_wrap_b = 0;
      m_pushes = 0;
    end else begin
      if (mem_we_a && mem_ready) begin
        log_addr_a.push_back(32'(mem_addr_a));
        log_data_a.push_back(mem_wdata_a);
      end
      if (mem_we_b && mem_ready) log_addr_b.push_back(32'(mem_addr_b));
      do_pop = (mq.size() != 0) && mem_ready;
      do_acc = cmd_valid && (mq.size() < DEPTH);
      if (do_pop) begin
        void'(mq.pop_front());
        if (m_addr_a == 255) m_wrap_a = 1;
        if (m_addr_b == 3) m_wrap_b = 1;
        m_addr_a = (m_addr_a + 1) % 256;
        m_addr_b = (m_addr_b + 1) % 4;
      end
      if (do_acc) begin
        if (cmd_kind <= 3'd4) begin
          mq.push_back(ref_encode(cmd_kind, cmd_rd, cmd_rs1, cmd_rs2,
                                  cmd_funct3, cmd_funct7, cmd_imm));
          m_pushes++;
        end else begin
          m_err = 1;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic set_cmd(logic [2:0] k, logic [4:0] rd, logic [4:0] rs1,
      logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [11:0] imm);
    cmd_kind = k; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_funct3 = f3; cmd_funct7 = f7; cmd_imm = imm;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    log_addr_a.delete(); log_data_a.delete(); log_addr_b.delete();
  endtask

  initial begin
    vecs[0] = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,  12'h000, 32'h002081B3}; // add x3,x1,x2
    vecs[1] = '{3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0,  12'h008, 32'h00812283}; // lw x5,8(x2)
    vecs[2] = '{3'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0,  12'h00C, 32'h00512623}; // sw x5,12(x2)
    vecs[3] = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,  12'h008, 32'h00208863}; // beq +16
    vecs[4] = '{3'd4, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0,  12'h003, 32'h00309093}; // slli x1,x1,3
    vecs[5] = '{3'd4, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 12'h005, 32'h40515093}; // srai x1,x2,5
    vecs[6] = '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  12'hFFF, 32'hFFF00093}; // addi x1,x0,-1
    vecs[7] = '{3'd3, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0,  12'hFFC, 32'hFE419CE3}; // bne -8

    // Reset with a command offered: it must not be taken.
    reset = 1'b1; mem_ready = 1'b1; cmd_valid = 1'b1;
    set_cmd(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0);
    step();
    step();
    chk("rst_wdata", mem_wdata_a, 32'd0);
    chk("rst_pending", pending_a, 32'd0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    step();

    // Vector table: each word appears one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      set_cmd(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
              vecs[i].f3, vecs[i].f7, vecs[i].imm);
      cmd_valid = 1'b1; mem_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk($sformatf("vec%0d_we", i), mem_we_a, 32'd1);
      chk($sformatf("vec%0d_word", i), mem_wdata_a, vecs[i].exp);
      step();
    end

    // lw then sw back to back.
    do_reset();
    mem_ready = 1'b1; cmd_valid = 1'b1;
    set_cmd(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 12'h008);
    step();
    chk("lw_word", mem_wdata_a, 32'h00812283);
    chk("lw_addr", mem_addr_a, 32'd0);
    set_cmd(3'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 12'h00C);
    step();
    cmd_valid = 1'b0;
    chk("sw_word", mem_wdata_a, 32'h00512623);
    chk("sw_addr", mem_addr_a, 32'd1);
    chk("sw_we", mem_we_a, 32'd1);
    step();

    // Backpressure: five commands against a stalled memory.
    do_reset();
    mem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cmd_valid = (m_pushes < 5);
      set_cmd(3'd0, 5'(m_pushes + 1), 5'd1, 5'd2, 3'd0, 7'd0, 12'd0);
      step();
    end
    chk("bp_pending", pending_a, 32'd4);
    chk("bp_ready", cmd_ready_a, 32'd0);
    mem_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cmd_valid = (m_pushes < 5);
      set_cmd(3'd0, 5'(m_pushes + 1), 5'd1, 5'd2, 3'd0, 7'd0, 12'd0);
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_count", log_addr_a.size(), 32'd5);
    for (int i = 0; i < 5 && i < log_addr_a.size(); i++) begin
      chk($sformatf("bp_addr%0d", i), log_addr_a[i], 32'(i));
      chk($sformatf("bp_data%0d", i), log_data_a[i], 32'h00208033 | (32'(i + 1) << 7));
    end

    // Illegal kind: consumed, flagged, nothing queued.
    do_reset();
    mem_ready = 1'b1; cmd_valid = 1'b1;
    set_cmd(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 12'd0);
    step();
    cmd_valid = 1'b0;
    chk("ill_err", err_illegal_a, 32'd1);
    chk("ill_we", mem_we_a, 32'd0);
    chk("ill_pending", pending_a, 32'd0);
    mem_ready = 1'b0; cmd_valid = 1'b1;
    set_cmd(3'd1, 5'd1, 5'd1, 5'd0, 3'd2, 7'd0, 12'd4);
    step();
    set_cmd(3'd6, 5'd1, 5'd1, 5'd0, 3'd2, 7'd0, 12'd4);
    step();
    cmd_valid = 1'b0;
    chk("ill_pending_held", pending_a, 32'd1);
    chk("ill_err_sticky", err_illegal_a, 32'd1);
    mem_ready = 1'b1;
    step();
    step();

    // Address wrap on the 2-bit instance.
    do_reset();
    mem_ready = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(3'd4, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 12'(i));
      step();
    end
    cmd_valid = 1'b0;
    step(); step(); step();
    chk("wrap_count", log_addr_b.size(), 32'd5);
    for (int i = 0; i < 5 && i < log_addr_b.size(); i++)
      chk($sformatf("wrap_addr%0d", i), log_addr_b[i], 32'(i % 4));
    chk("wrap_flag_b", addr_wrap_b, 32'd1);
    chk("wrap_flag_a", addr_wrap_a, 32'd0);

    // Reset mid-stream with two words pending and a command offered.
    mem_ready = 1'b0; cmd_valid = 1'b1;
    set_cmd(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0);
    step();
    set_cmd(3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 12'd0);
    step();
    step();
    chk("mid_pending", pending_b, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0; cmd_valid = 1'b0;
    chk("mid_we", mem_we_b, 32'd0);
    chk("mid_pending0", pending_b, 32'd0);
    chk("mid_addr", mem_addr_b, 32'd0);
    chk("mid_wrap", addr_wrap_b, 32'd0);
    chk("mid_err", err_illegal_b, 32'd0);
    chk("mid_wdata", mem_wdata_b, 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      set_cmd(($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
              5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
              7'($urandom), 12'($urandom));
      step();
    end
    reset = 1'b0; cmd_valid = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
